// File: rtl/flx_pkg.sv
// Shared types and helpers for the free-list exchange scheduler.
package flx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDY   = 2'd1,
        SCAN  = 2'd2,
        WRITE = 2'd3
    } flx_state_t;

    localparam int unsigned TAG_MAX_W = 32;

    // Drops the low dist_width bits of an iteration index; callers narrow the result.
    function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [TAG_MAX_W-1:0] it,
                                                    input int unsigned dist_width);
        return it >> dist_width;
    endfunction

endpackage

// File: rtl/fl_exchange_scheduler_lsb_onehot_sel.sv
// Lowest-set-bit selector: one-hot grant plus the matching entry of a packed data vector.
module lsb_onehot_sel #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned DATA_W = 9
) (
    input  logic [WIDTH-1:0]        req,
    input  logic [WIDTH*DATA_W-1:0] data,
    output logic                    found_c,
    output logic [DATA_W-1:0]       value_c,
    output logic [WIDTH-1:0]        onehot_c
);

    assign found_c  = |req;
    assign onehot_c = req & (~req + WIDTH'(1));

    always_comb begin
        value_c = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (onehot_c[k]) value_c = value_c | data[k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/fl_exchange_scheduler.sv
// Free-list exchange scheduler: queues free entries in a persistent circular FIFO and pairs them with
// no-redundancy elements under a tag compare. Optional FLX_STATS_EN adds exch_cnt/drop_cnt counters.
module fl_exchange_scheduler
    import flx_pkg::*;
#(
    parameter int unsigned ITER_WIDTH = 9,
    parameter int unsigned DIST_WIDTH = 7,
    parameter int unsigned STEP_RANGE = 128,
    parameter int unsigned FL_SIZE    = 128,
    parameter int unsigned PTR_WIDTH  = $clog2(FL_SIZE),
    parameter int unsigned CNT_WIDTH  = $clog2(FL_SIZE + 1),
    parameter int unsigned CMP_STRICT = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             set_idle,
    input  logic                             enable_in,
    input  logic                             write_fin,
    input  logic [STEP_RANGE-1:0]            fl_enable_ch,
    input  logic [STEP_RANGE*ITER_WIDTH-1:0] fl_it_in,
    input  logic [STEP_RANGE-1:0]            nr_enable_ch,
    input  logic [STEP_RANGE*ITER_WIDTH-1:0] nr_it_in,
    output logic                             available,
    output logic                             valid,
    output logic                             nxt_exchange,
    output logic [ITER_WIDTH-1:0]            e_src_it,
    output logic [ITER_WIDTH-1:0]            e_dest_it,
    output logic                             step_done,
    output logic [CNT_WIDTH-1:0]             fl_count,
`ifdef FLX_STATS_EN
    output logic [15:0]                      exch_cnt,
    output logic [15:0]                      drop_cnt,
`endif
    output logic                             fl_overflow
);

    localparam int unsigned TAG_W = ITER_WIDTH - DIST_WIDTH;
    localparam int unsigned VEC_W = STEP_RANGE * ITER_WIDTH;

    flx_state_t state, state_nx;
    logic [STEP_RANGE-1:0] fl_bits, fl_bits_nx, nr_bits, nr_bits_nx;
    logic [VEC_W-1:0]      fl_its, fl_its_nx, nr_its, nr_its_nx;
    logic [PTR_WIDTH-1:0]  head, head_nx, tail, tail_nx;
    logic [CNT_WIDTH-1:0]  count_nx;
    logic [ITER_WIDTH-1:0] mem [FL_SIZE];
    logic [ITER_WIDTH-1:0] head_it, e_src_nx, e_dest_nx;
    logic                  valid_nx, nxt_nx, done_nx, ovf_nx, push, pop;

    logic                  f_found, n_found;
    logic [ITER_WIDTH-1:0] f_it, n_it;
    logic [STEP_RANGE-1:0] f_mask, n_mask;
    logic [TAG_W-1:0]      head_tag, n_tag;
    logic                  full, empty, cmp_ok;

    lsb_onehot_sel #(.WIDTH(STEP_RANGE), .DATA_W(ITER_WIDTH)) u_fl_sel (
        .req(fl_bits), .data(fl_its), .found_c(f_found), .value_c(f_it), .onehot_c(f_mask)
    );

    lsb_onehot_sel #(.WIDTH(STEP_RANGE), .DATA_W(ITER_WIDTH)) u_nr_sel (
        .req(nr_bits), .data(nr_its), .found_c(n_found), .value_c(n_it), .onehot_c(n_mask)
    );

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(FL_SIZE - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign head_it  = mem[head];
    assign head_tag = TAG_W'(tag_of(TAG_MAX_W'(head_it), DIST_WIDTH));
    assign n_tag    = TAG_W'(tag_of(TAG_MAX_W'(n_it), DIST_WIDTH));
    assign full     = (fl_count == CNT_WIDTH'(FL_SIZE));
    assign empty    = (fl_count == '0);
    assign cmp_ok   = (CMP_STRICT != 0) ? (head_tag < n_tag) : (head_tag <= n_tag);

    // Next-state and datapath decode; set_idle overrides every other event.
    always_comb begin
        state_nx   = state;
        fl_bits_nx = fl_bits;
        nr_bits_nx = nr_bits;
        fl_its_nx  = fl_its;
        nr_its_nx  = nr_its;
        head_nx    = head;
        tail_nx    = tail;
        count_nx   = fl_count;
        valid_nx   = valid;
        e_src_nx   = e_src_it;
        e_dest_nx  = e_dest_it;
        nxt_nx     = 1'b0;
        done_nx    = 1'b0;
        ovf_nx     = fl_overflow;
        push       = 1'b0;
        pop        = 1'b0;
        if (set_idle) begin
            state_nx   = IDLE;
            fl_bits_nx = '0;
            nr_bits_nx = '0;
            fl_its_nx  = '0;
            nr_its_nx  = '0;
            head_nx    = '0;
            tail_nx    = '0;
            count_nx   = '0;
            valid_nx   = 1'b0;
            e_src_nx   = '0;
            e_dest_nx  = '0;
            ovf_nx     = 1'b0;
        end else begin
            case (state)
                IDLE: state_nx = RDY;
                RDY: begin
                    if (enable_in) begin
                        fl_bits_nx = fl_enable_ch;
                        nr_bits_nx = nr_enable_ch;
                        fl_its_nx  = fl_it_in;
                        nr_its_nx  = nr_it_in;
                        state_nx   = SCAN;
                    end
                end
                SCAN: begin
                    if (fl_bits == '0 && nr_bits == '0) begin
                        done_nx  = 1'b1;
                        state_nx = RDY;
                    end else begin
                        if (f_found && !full) begin
                            push       = 1'b1;
                            fl_bits_nx = fl_bits & ~f_mask;
                        end
                        // Pairing looks at the pre-push head, so a same-cycle push is never popped.
                        if (n_found && !empty) begin
                            nr_bits_nx = nr_bits & ~n_mask;
                            if (cmp_ok) begin
                                pop       = 1'b1;
                                valid_nx  = 1'b1;
                                e_src_nx  = head_it;
                                e_dest_nx = n_it;
                                state_nx  = WRITE;
                            end
                        end else if (n_found && !f_found) begin
                            nr_bits_nx = '0;
                        end
                        // Full FIFO with nothing left to drain it: discard the rest to avoid deadlock.
                        if (f_found && full && !n_found) begin
                            fl_bits_nx = '0;
                            ovf_nx     = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (write_fin) begin
                        valid_nx = 1'b0;
                        nxt_nx   = 1'b1;
                        state_nx = SCAN;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (push) tail_nx = ptr_inc(tail);
            if (pop)  head_nx = ptr_inc(head);
            count_nx = fl_count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            fl_bits      <= '0;
            nr_bits      <= '0;
            fl_its       <= '0;
            nr_its       <= '0;
            head         <= '0;
            tail         <= '0;
            fl_count     <= '0;
            valid        <= 1'b0;
            e_src_it     <= '0;
            e_dest_it    <= '0;
            nxt_exchange <= 1'b0;
            step_done    <= 1'b0;
            fl_overflow  <= 1'b0;
            available    <= 1'b0;
        end else begin
            state        <= state_nx;
            fl_bits      <= fl_bits_nx;
            nr_bits      <= nr_bits_nx;
            fl_its       <= fl_its_nx;
            nr_its       <= nr_its_nx;
            head         <= head_nx;
            tail         <= tail_nx;
            fl_count     <= count_nx;
            valid        <= valid_nx;
            e_src_it     <= e_src_nx;
            e_dest_it    <= e_dest_nx;
            nxt_exchange <= nxt_nx;
            step_done    <= done_nx;
            fl_overflow  <= ovf_nx;
            available    <= (state_nx == RDY);
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= f_it;
    end

`ifdef FLX_STATS_EN
    localparam int unsigned POP_W = $clog2(STEP_RANGE + 1);

    logic [POP_W-1:0] nr_pop;
    logic [16:0]      exch_sum, drop_sum;
    logic             exch_ev, drop_one, drop_all;

    assign exch_ev  = !set_idle && (state == WRITE) && write_fin;
    assign drop_one = !set_idle && (state == SCAN) && n_found && !empty && !cmp_ok;
    assign drop_all = !set_idle && (state == SCAN) && n_found && empty && !f_found;

    always_comb begin
        nr_pop = '0;
        for (int unsigned k = 0; k < STEP_RANGE; k++) nr_pop = nr_pop + POP_W'(nr_bits[k]);
        exch_sum = 17'(exch_cnt) + 17'(exch_ev);
        drop_sum = 17'(drop_cnt) + (drop_all ? 17'(nr_pop) : 17'(drop_one));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exch_cnt <= '0;
            drop_cnt <= '0;
        end else if (set_idle) begin
            exch_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            exch_cnt <= exch_sum[16] ? 16'hFFFF : exch_sum[15:0];
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fl_exchange_scheduler.sv
// Scoreboard bench: a strict-compare instance (FL_SIZE=3) and a non-strict instance (FL_SIZE=5).
module tb_fl_exchange_scheduler;

    localparam int unsigned IW  = 9;
    localparam int unsigned SR  = 8;
    localparam int unsigned CW1 = $clog2(3 + 1);
    localparam int unsigned CW2 = $clog2(5 + 1);

    typedef struct packed {
        logic [IW-1:0] src;
        logic [IW-1:0] dst;
    } pair_t;

    logic clk = 1'b0;
    logic reset_n, set_idle, enable_in, enable2, write_fin;
    logic [SR-1:0]    fl_en, nr_en;
    logic [SR*IW-1:0] fl_it, nr_it;

    logic available, valid, nxt_exchange, step_done, fl_overflow;
    logic [IW-1:0] e_src_it, e_dest_it;
    logic [CW1-1:0] fl_count;
    logic available2, valid2, nxt2, step_done2, ovf2;
    logic [IW-1:0] src2, dst2;
    logic [CW2-1:0] count2;
`ifdef FLX_STATS_EN
    logic [15:0] exch_a, drop_a, exch_b, drop_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int nxt_seen = 0;
    int nxt_seen2 = 0;
    pair_t exp_q[$];
    pair_t exp_q2[$];

    always #5 clk = ~clk;

    fl_exchange_scheduler #(.ITER_WIDTH(IW), .DIST_WIDTH(7), .STEP_RANGE(SR), .FL_SIZE(3),
                            .CMP_STRICT(1)) dut (
        .clk(clk), .reset_n(reset_n), .set_idle(set_idle), .enable_in(enable_in),
        .write_fin(write_fin), .fl_enable_ch(fl_en), .fl_it_in(fl_it), .nr_enable_ch(nr_en),
        .nr_it_in(nr_it), .available(available), .valid(valid), .nxt_exchange(nxt_exchange),
        .e_src_it(e_src_it), .e_dest_it(e_dest_it), .step_done(step_done), .fl_count(fl_count),
`ifdef FLX_STATS_EN
        .exch_cnt(exch_a), .drop_cnt(drop_a),
`endif
        .fl_overflow(fl_overflow)
    );

    fl_exchange_scheduler #(.ITER_WIDTH(IW), .DIST_WIDTH(7), .STEP_RANGE(SR), .FL_SIZE(5),
                            .CMP_STRICT(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .set_idle(set_idle), .enable_in(enable2),
        .write_fin(write_fin), .fl_enable_ch(fl_en), .fl_it_in(fl_it), .nr_enable_ch(nr_en),
        .nr_it_in(nr_it), .available(available2), .valid(valid2), .nxt_exchange(nxt2),
        .e_src_it(src2), .e_dest_it(dst2), .step_done(step_done2), .fl_count(count2),
`ifdef FLX_STATS_EN
        .exch_cnt(exch_b), .drop_cnt(drop_b),
`endif
        .fl_overflow(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Monitor for the strict instance: pops on each new presentation, checks hold while stalled.
    logic  prev_v = 1'b0;
    pair_t cur;
    always @(negedge clk) begin
        if (nxt_exchange) nxt_seen++;
        if (valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got src=0x%0h dest=0x%0h required no exchange",
                         e_src_it, e_dest_it);
            end else begin
                cur = exp_q.pop_front();
                check("e_src_it", 32'(e_src_it), 32'(cur.src));
                check("e_dest_it", 32'(e_dest_it), 32'(cur.dst));
            end
        end else if (valid && prev_v) begin
            check("hold_src", 32'(e_src_it), 32'(cur.src));
            check("hold_dest", 32'(e_dest_it), 32'(cur.dst));
        end
        prev_v = valid;
    end

    logic  prev_v2 = 1'b0;
    pair_t cur2;
    always @(negedge clk) begin
        if (nxt2) nxt_seen2++;
        if (valid2 && !prev_v2) begin
            if (exp_q2.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid2: got src=0x%0h dest=0x%0h required no exchange",
                         src2, dst2);
            end else begin
                cur2 = exp_q2.pop_front();
                check("e_src_it2", 32'(src2), 32'(cur2.src));
                check("e_dest_it2", 32'(dst2), 32'(cur2.dst));
            end
        end
        prev_v2 = valid2;
    end

    task automatic clear_vecs();
        fl_en = '0; nr_en = '0; fl_it = '0; nr_it = '0;
    endtask

    task automatic set_fl(input int k, input logic [IW-1:0] v);
        fl_en[k] = 1'b1;
        fl_it[k*IW +: IW] = v;
    endtask

    task automatic set_nr(input int k, input logic [IW-1:0] v);
        nr_en[k] = 1'b1;
        nr_it[k*IW +: IW] = v;
    endtask

    task automatic expect_pair(input logic [IW-1:0] s, input logic [IW-1:0] d);
        pair_t p;
        p.src = s;
        p.dst = d;
        exp_q.push_back(p);
    endtask

    task automatic wait_avail();
        int t = 0;
        while (!available && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("available", 32'(available), 32'd1);
    endtask

    task automatic start_step(input logic both);
        enable_in = 1'b1;
        enable2   = both;
        @(negedge clk);
        enable_in = 1'b0;
        enable2   = 1'b0;
    endtask

    task automatic wait_done(input logic need2);
        logic s1 = 1'b0;
        logic s2 = ~need2;
        int t = 0;
        while (!(s1 && s2) && t < 300) begin
            @(negedge clk);
            if (step_done) s1 = 1'b1;
            if (step_done2) s2 = 1'b1;
            t++;
        end
        check("step_done_seen", 32'(s1 && s2), 32'd1);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("valid_seen", 32'(valid), 32'd1);
    endtask

    task automatic flush();
        set_idle = 1'b1;
        @(negedge clk);
        set_idle = 1'b0;
        check("flush_count", 32'(fl_count), 32'd0);
        check("flush_ovf", 32'(fl_overflow), 32'd0);
        check("flush_avail", 32'(available), 32'd0);
    endtask

    task automatic run(input int exp_cnt, input logic exp_ovf, input int exp_nxt);
        int n0 = nxt_seen;
        wait_avail();
        start_step(1'b0);
        wait_done(1'b0);
        check("fl_count", 32'(fl_count), 32'(exp_cnt));
        check("fl_overflow", 32'(fl_overflow), 32'(exp_ovf));
        check("nxt_pulses", 32'(nxt_seen - n0), 32'(exp_nxt));
    endtask

    int n1, n2;

    initial begin
        reset_n = 1'b0; set_idle = 1'b0; enable_in = 1'b0; enable2 = 1'b0; write_fin = 1'b1;
        clear_vecs();
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_avail", 32'(available), 32'd0);
        check("rst_count", 32'(fl_count), 32'd0);
        check("rst_done", 32'(step_done), 32'd0);
        reset_n = 1'b1;

        // Equal tags: dropped when strict, exchanged when non-strict.
        wait_avail();
        check("available2", 32'(available2), 32'd1);
        clear_vecs(); set_fl(0, 9'h080); set_nr(0, 9'h0BF);
        exp_q2.push_back(pair_t'{9'h080, 9'h0BF});
        n1 = nxt_seen; n2 = nxt_seen2;
        start_step(1'b1);
        wait_done(1'b1);
        check("cmp_strict_count", 32'(fl_count), 32'd1);
        check("cmp_strict_nxt", 32'(nxt_seen - n1), 32'd0);
        check("cmp_le_count", 32'(count2), 32'd0);
        check("cmp_le_nxt", 32'(nxt_seen2 - n2), 32'd1);
        flush();

        // Basic pair.
        wait_avail();
        clear_vecs(); set_fl(0, 9'h005); set_nr(0, 9'h100);
        expect_pair(9'h005, 9'h100);
        run(0, 1'b0, 1);

        // LSB-first ordering.
        wait_avail();
        clear_vecs(); set_fl(3, 9'h033); set_fl(1, 9'h011); set_nr(2, 9'h1C2); set_nr(0, 9'h1A0);
        expect_pair(9'h011, 9'h1A0);
        expect_pair(9'h033, 9'h1C2);
        run(0, 1'b0, 2);

        // Overflow: five candidates into a depth-3 FIFO with nothing to drain it.
        wait_avail();
        clear_vecs();
        for (int k = 0; k < 5; k++) set_fl(k, 9'(k + 1));
        run(3, 1'b1, 0);
        flush();

        // Persistence across steps and pointer wrap.
        wait_avail();
        clear_vecs(); set_fl(0, 9'h010); set_fl(1, 9'h020);
        run(2, 1'b0, 0);
        wait_avail();
        clear_vecs(); set_nr(0, 9'h1FF);
        expect_pair(9'h010, 9'h1FF);
        run(1, 1'b0, 1);
        wait_avail();
        clear_vecs(); set_fl(0, 9'h030); set_fl(1, 9'h040);
        run(3, 1'b0, 0);
        wait_avail();
        clear_vecs(); set_nr(0, 9'h180); set_nr(1, 9'h181); set_nr(2, 9'h182);
        expect_pair(9'h020, 9'h180);
        expect_pair(9'h030, 9'h181);
        expect_pair(9'h040, 9'h182);
        run(0, 1'b0, 3);

        // set_idle while an exchange is stalled in WRITE.
        write_fin = 1'b0;
        wait_avail();
        clear_vecs(); set_fl(0, 9'h007); set_fl(1, 9'h008); set_nr(0, 9'h107);
        expect_pair(9'h007, 9'h107);
        start_step(1'b0);
        wait_valid();
        repeat (3) @(negedge clk);
        check("write_count", 32'(fl_count), 32'd1);
        n1 = nxt_seen;
        set_idle = 1'b1;
        @(negedge clk);
        set_idle = 1'b0;
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_count", 32'(fl_count), 32'd0);
        check("idle_nxt", 32'(nxt_exchange), 32'd0);
        @(negedge clk);
        check("idle_nxt_pulses", 32'(nxt_seen - n1), 32'd0);

        // Asynchronous reset while an exchange is stalled in WRITE.
        wait_avail();
        expect_pair(9'h007, 9'h107);
        start_step(1'b0);
        wait_valid();
        repeat (2) @(negedge clk);
        n1 = nxt_seen;
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_count", 32'(fl_count), 32'd0);
        check("arst_nxt", 32'(nxt_exchange), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        write_fin = 1'b1;
        wait_avail();
        check("arst_nxt_pulses", 32'(nxt_seen - n1), 32'd0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("exp_q2_drained", 32'(exp_q2.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fl_exchange_scheduler.md
Name: fl_exchange_scheduler

Overview:
- Successor free-list exchange controller for the redundancy controller.
- Each step, it latches a vector of free-list candidates and a vector of no-redundancy elements, and queues the free entries in a circular FIFO.
- It pairs queued entries with no-redundancy elements, one exchange at a time, under a tag comparison, and hands each pair to the writer through a valid/write_fin handshake.
- Unlike the previous generation, the FIFO persists across steps, depth need not be a power of two, the compare mode is selectable, and overflow and drops are handled explicitly.

Parameters:
- ITER_WIDTH, 9: width of one iteration index.
- DIST_WIDTH, 7: low index bits ignored by the compare; tag = it[ITER_WIDTH-1:DIST_WIDTH].
- STEP_RANGE, 128: entries per input vector.
- FL_SIZE, 128: FIFO depth, any value ≥2.
- PTR_WIDTH, $clog2(FL_SIZE): FIFO pointer width.
- CNT_WIDTH, $clog2(FL_SIZE+1): occupancy width.
- CMP_STRICT, 1: 1 = exchange if src tag < dest tag; 0 = exchange if src tag ≤ dest tag.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- set_idle  in  1  synchronous flush; FIFO and all state cleared
- enable_in  in  1  start a step; sampled only in RDY
- write_fin  in  1  writer accepted the current exchange
- fl_enable_ch  in  STEP_RANGE  free-list candidate valid bits
- fl_it_in  in  STEP_RANGE*ITER_WIDTH  free-list candidate indices; entry k at [k*ITER_WIDTH +: ITER_WIDTH]
- nr_enable_ch  in  STEP_RANGE  no-redundancy element valid bits
- nr_it_in  in  STEP_RANGE*ITER_WIDTH  no-redundancy indices, same packing
- available  out  1  high in RDY only
- valid  out  1  exchange pair presented
- nxt_exchange  out  1  one-cycle pulse on exchange acceptance
- e_src_it  out  ITER_WIDTH  exchange source (FIFO head)
- e_dest_it  out  ITER_WIDTH  exchange destination
- step_done  out  1  one-cycle pulse when a step completes
- fl_count  out  CNT_WIDTH  FIFO occupancy
- fl_overflow  out  1  sticky; a candidate was discarded because the FIFO was full

Behaviour:
- Reset: all outputs 0; state IDLE; pointers, count and latched vectors cleared.
- set_idle in any state: state goes to IDLE next cycle with the same clearing as reset; set_idle has priority over all other events.
- IDLE -> RDY unconditionally.
- RDY:
  - available=1.
  - enable_in=1 latches both enable vectors and both index vectors; go to SCAN.
  - Inputs are ignored outside RDY.
- SCAN, one cycle per iteration:
  - F = lowest set latched fl bit; N = lowest set latched nr bit (LSB-first priority).
  - Push: if F exists and count<FL_SIZE, write its index at the tail and clear the bit.
  - Pop/pair: if N exists and count>0 (pre-push count; the head is never the same-cycle push):
    - if compare(head tag, N tag) passes: latch e_src_it=head and e_dest_it=N, pop, clear N, set valid=1, go to WRITE;
    - otherwise clear N (dropped), no pop.
  - N exists, count=0, and F exists: N waits.
  - N exists, count=0, no F remaining: all remaining nr bits cleared.
  - F exists, FIFO full, and no nr bits remain: all remaining fl bits cleared and fl_overflow set. This prevents deadlock.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Both latched vectors zero: step_done pulses, go to RDY. The FIFO is retained for the next step.
- WRITE:
  - valid, e_src_it and e_dest_it are held stable.
  - write_fin=1: valid drops next cycle, nxt_exchange pulses for one cycle, return to SCAN.
  - write_fin while not in WRITE is ignored.
- Latency: at least 2 cycles from RDY+enable_in to first valid (LOAD into SCAN, then WRITE). Throughput is one exchange per 2 cycles with write_fin tied high.
- Pointers wrap from FL_SIZE-1 to 0. Full and empty derive from fl_count, never from pointer equality.
- Tags compare unsigned, width ITER_WIDTH-DIST_WIDTH.
- Reset asserted mid-WRITE: valid falls asynchronously and no nxt_exchange is issued.

Optional Feature:
- FLX_STATS_EN defined: adds outputs exch_cnt (16 bits) and drop_cnt (16 bits).
  - exch_cnt increments on each nxt_exchange; drop_cnt increments per nr bit cleared without exchange.
  - Both saturate at 16'hFFFF and are cleared by reset or set_idle.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package flx_pkg: state encoding (IDLE, RDY, SCAN, WRITE) and a tag-extract function parameterised by ITER_WIDTH/DIST_WIDTH.
- One sub-module, lsb_onehot_sel: lowest-set-bit one-hot plus mux returning a found flag, the index value and the one-hot mask. Instantiate it twice, for fl and nr.

Test Plan:
- Basic pair: fl bit0=9'h005, nr bit0=9'h100, write_fin held high -> valid with e_src_it=005, e_dest_it=100; nxt_exchange pulse; step_done; fl_count=0.
- Compare mode: head 9'h080 and nr 9'h0BF (equal tags) -> dropped with CMP_STRICT=1, exchanged with CMP_STRICT=0.
- Ordering: fl bits 3,1 and nr bits 2,0 -> exchanges issued in order (fl1,nr0) then (fl3,nr2).
- Overflow: FL_SIZE=3, 5 fl bits, no nr -> fl_count=3, fl_overflow=1, step_done pulses, no valid.
- Persistence and wrap: FL_SIZE=3, over three steps push 2 / pop 1 / push 2 -> pointers wrap and pops return FIFO order.
- Flush/reset: set_idle during WRITE -> next cycle valid=0, fl_count=0, no nxt_exchange; repeat with reset_n low -> same result asynchronously.
